// File: rtl/params_pkg.sv
// Shared sizing for the data-memory path.
package params_pkg;
  localparam int MEM_SIZE   = 16;
  localparam int ADDR_WIDTH = 8;
  localparam int DATA_WIDTH = 32;
endpackage

// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter: one outstanding access, alternating priority on contention.
//   state  | meaning
//   IDLE   | waiting for a request; combinational grant to one requester
//   ACCESS | latched request driven onto the memory port for one cycle
//   RESP   | one-cycle response pulse to the owner
module dmem_arbiter #(
  parameter int MEM_SIZE   = params_pkg::MEM_SIZE,
  parameter int ADDR_WIDTH = params_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = params_pkg::DATA_WIDTH
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [1:0]                 req_valid_i,
  output logic [1:0]                 req_ready_o,
  input  logic [1:0]                 req_we_i,
  input  logic [1:0][ADDR_WIDTH-1:0] req_addr_i,
  input  logic [1:0][DATA_WIDTH-1:0] req_wdata_i,
  output logic [1:0]                 rsp_valid_o,
  output logic [DATA_WIDTH-1:0]      rsp_rdata_o,
  output logic                       rsp_err_o,
  output logic                       mem_wr_en_o,
  output logic [ADDR_WIDTH-1:0]      mem_addr_o,
  output logic [DATA_WIDTH-1:0]      mem_wr_data_o,
  input  logic [DATA_WIDTH-1:0]      mem_rd_data_i,
  output logic                       busy_o
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [ADDR_WIDTH:0] MEM_LIMIT = (ADDR_WIDTH+1)'(MEM_SIZE);

  state_t                state_q;
  logic                  prio_q;
  logic                  owner_q;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic win;
  logic accept;
  logic in_range;

  // Contention goes to the pointer; a lone request always wins.
  always_comb begin
    win = 1'b0;
    if (&req_valid_i) win = prio_q;
    else              win = req_valid_i[1];
  end

  // Gated by reset so no grant leaks out while rst_i is held low.
  assign accept   = (state_q == IDLE) && rst_i && (|req_valid_i);
  assign in_range = {1'b0, addr_q} < MEM_LIMIT;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      owner_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|req_valid_i) begin
            state_q <= ACCESS;
            owner_q <= win;
            we_q    <= req_we_i[win];
            addr_q  <= req_addr_i[win];
            wdata_q <= req_wdata_i[win];
            prio_q  <= ~win;
          end
        end
        ACCESS: begin
          rdata_q <= (!we_q && in_range) ? mem_rd_data_i : '0;
          state_q <= RESP;
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready_o   = accept ? (win ? 2'b10 : 2'b01) : 2'b00;
  assign mem_wr_en_o   = (state_q == ACCESS) && we_q && in_range;
  assign mem_addr_o    = (state_q == ACCESS) ? addr_q  : '0;
  assign mem_wr_data_o = (state_q == ACCESS) ? wdata_q : '0;
  assign rsp_valid_o   = (state_q == RESP) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_rdata_o   = (state_q == RESP) ? rdata_q : '0;
  assign rsp_err_o     = (state_q == RESP) && !in_range;
  assign busy_o        = (state_q != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a behavioural data memory initialised to mem[i] = i.
module tb_dmem_arbiter;
  localparam int MS = params_pkg::MEM_SIZE;
  localparam int AW = params_pkg::ADDR_WIDTH;
  localparam int DW = params_pkg::DATA_WIDTH;
  localparam int IW = $clog2(MS);

  logic                clk_i;
  logic                rst_i;
  logic [1:0]          req_valid;
  logic [1:0]          req_ready;
  logic [1:0]          req_we;
  logic [1:0][AW-1:0]  req_addr;
  logic [1:0][DW-1:0]  req_wdata;
  logic [1:0]          rsp_valid;
  logic [DW-1:0]       rsp_rdata;
  logic                rsp_err;
  logic                mem_wr_en;
  logic [AW-1:0]       mem_addr;
  logic [DW-1:0]       mem_wr_data;
  logic [DW-1:0]       mem_rd_data;
  logic                busy;

  logic [DW-1:0] mem     [MS];
  logic [DW-1:0] ref_mem [MS];

  typedef struct {
    logic [1:0]    onehot;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          err;
  } exp_t;
  exp_t sb_q[$];

  int total;
  int bad;

  dmem_arbiter dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
    .mem_wr_en_o(mem_wr_en), .mem_addr_o(mem_addr), .mem_wr_data_o(mem_wr_data),
    .mem_rd_data_i(mem_rd_data), .busy_o(busy)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  assign mem_rd_data = (int'(mem_addr) < MS) ? mem[mem_addr[IW-1:0]] : '0;

  task automatic env_mem();
    for (int i = 0; i < MS; i++) mem[i] = DW'(i);
    forever begin
      @(negedge clk_i);
      if (mem_wr_en && int'(mem_addr) < MS) mem[mem_addr[IW-1:0]] = mem_wr_data;
    end
  endtask

  task automatic scoreboard();
    exp_t e;
    int   i;
    for (int k = 0; k < MS; k++) ref_mem[k] = DW'(k);
    forever begin
      @(negedge clk_i);
      if (!rst_i) begin
        sb_q.delete();
      end else begin
        if (rsp_valid != 2'b00) begin
          total++;
          if (sb_q.size() == 0) begin
            bad++;
            $display("FAIL sb_unexpected_rsp got valid=%b want none", rsp_valid);
          end else begin
            e = sb_q.pop_front();
            if (rsp_valid !== e.onehot || rsp_rdata !== e.rdata || rsp_err !== e.err) begin
              bad++;
              $display("FAIL sb_rsp got valid=%b rdata=%h err=%b want valid=%b rdata=%h err=%b",
                       rsp_valid, rsp_rdata, rsp_err, e.onehot, e.rdata, e.err);
            end
            if (e.we && !e.err) ref_mem[e.addr[IW-1:0]] = e.wdata;
          end
        end
        if (req_ready != 2'b00) begin
          total++;
          if (req_ready !== 2'b01 && req_ready !== 2'b10) begin
            bad++;
            $display("FAIL ready_onehot got=%b want 01 or 10", req_ready);
          end
          i        = req_ready[1] ? 1 : 0;
          e.onehot = (i == 1) ? 2'b10 : 2'b01;
          e.we     = req_we[i];
          e.addr   = req_addr[i];
          e.wdata  = req_wdata[i];
          e.err    = (int'(e.addr) >= MS);
          e.rdata  = (!e.we && !e.err) ? ref_mem[e.addr[IW-1:0]] : '0;
          sb_q.push_back(e);
        end
      end
    end
  endtask

  // Drives one request, holds it until granted, then captures the response cycle (T+2).
  task automatic issue(input int idx, input logic we, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wdata, output int wait_cyc, output int wr_cyc,
                       output logic [1:0] rsp_v, output logic [DW-1:0] rsp_d, output logic rsp_e);
    wait_cyc = 0; wr_cyc = 0; rsp_v = 2'b00; rsp_d = '0; rsp_e = 1'b0;
    @(posedge clk_i); #1;
    req_valid[idx] = 1'b1; req_we[idx] = we; req_addr[idx] = addr; req_wdata[idx] = wdata;
    @(negedge clk_i);
    while (!req_ready[idx] && wait_cyc < 20) begin
      wait_cyc++;
      @(negedge clk_i);
    end
    total++;
    if (!req_ready[idx]) begin
      bad++;
      $display("FAIL issue_timeout req=%0d got ready=%b want grant", idx, req_ready);
      req_valid[idx] = 1'b0;
    end else begin
      @(posedge clk_i); #1;
      req_valid[idx] = 1'b0;
      @(negedge clk_i); wr_cyc += int'(mem_wr_en);
      @(negedge clk_i); wr_cyc += int'(mem_wr_en);
      rsp_v = rsp_valid; rsp_d = rsp_rdata; rsp_e = rsp_err;
      @(negedge clk_i); wr_cyc += int'(mem_wr_en);
    end
  endtask

  task automatic test_reset();
    req_valid = 2'b11; req_we = 2'b11; req_addr[0] = AW'(3); req_addr[1] = AW'(3);
    req_wdata[0] = DW'(32'hAA); req_wdata[1] = DW'(32'hBB);
    #12;
    total++;
    if (req_ready !== 2'b00 || rsp_valid !== 2'b00 || busy !== 1'b0) begin
      bad++; $display("FAIL reset_ctrl got ready=%b rsp=%b busy=%b want 0", req_ready, rsp_valid, busy);
    end
    total++;
    if (rsp_rdata !== '0 || rsp_err !== 1'b0) begin
      bad++; $display("FAIL reset_rsp got rdata=%h err=%b want 0", rsp_rdata, rsp_err);
    end
    total++;
    if (mem_wr_en !== 1'b0 || mem_addr !== '0 || mem_wr_data !== '0) begin
      bad++; $display("FAIL reset_mem got we=%b addr=%h data=%h want 0", mem_wr_en, mem_addr, mem_wr_data);
    end
    @(posedge clk_i); #1;
    total++;
    if (busy !== 1'b0 || req_ready !== 2'b00) begin
      bad++; $display("FAIL reset_hold got busy=%b ready=%b want 0", busy, req_ready);
    end
    req_valid = 2'b00; req_we = 2'b00;
    @(negedge clk_i); #1;
    rst_i = 1'b1;
    #1;
    total++;
    if (busy !== 1'b0 || req_ready !== 2'b00 || mem_wr_en !== 1'b0 || rsp_valid !== 2'b00) begin
      bad++; $display("FAIL reset_release got busy=%b ready=%b we=%b rsp=%b want 0", busy, req_ready, mem_wr_en, rsp_valid);
    end
  endtask

  task automatic test_fresh_read();
    @(posedge clk_i); #1;
    req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = AW'(5);
    @(negedge clk_i);
    total++;
    if (req_ready !== 2'b01 || busy !== 1'b0) begin
      bad++; $display("FAIL fresh_grant got ready=%b busy=%b want 01/0", req_ready, busy);
    end
    @(posedge clk_i); #1;
    req_valid[0] = 1'b0;
    @(negedge clk_i);
    total++;
    if (busy !== 1'b1 || mem_addr !== AW'(5) || mem_wr_en !== 1'b0 || req_ready !== 2'b00) begin
      bad++; $display("FAIL fresh_access got busy=%b addr=%h we=%b ready=%b want 1/05/0/00", busy, mem_addr, mem_wr_en, req_ready);
    end
    @(negedge clk_i);
    total++;
    if (busy !== 1'b1 || rsp_valid !== 2'b01 || rsp_rdata !== DW'(5) || rsp_err !== 1'b0) begin
      bad++; $display("FAIL fresh_resp got busy=%b rsp=%b rdata=%h err=%b want 1/01/5/0", busy, rsp_valid, rsp_rdata, rsp_err);
    end
    @(negedge clk_i);
    total++;
    if (busy !== 1'b0 || rsp_valid !== 2'b00) begin
      bad++; $display("FAIL fresh_done got busy=%b rsp=%b want 0/00", busy, rsp_valid);
    end
  endtask

  task automatic test_write_read();
    int w, wr; logic [1:0] v; logic [DW-1:0] d; logic e;
    issue(0, 1'b1, AW'(3), DW'(32'hAA), w, wr, v, d, e);
    total++;
    if (wr != 1 || v !== 2'b01 || e !== 1'b0 || d !== '0) begin
      bad++; $display("FAIL wr_access got wr_cycles=%0d rsp=%b err=%b rdata=%h want 1/01/0/0", wr, v, e, d);
    end
    total++;
    if (mem[3] !== DW'(32'hAA)) begin
      bad++; $display("FAIL wr_mem got=%h want=000000aa", mem[3]);
    end
    issue(0, 1'b0, AW'(3), '0, w, wr, v, d, e);
    total++;
    if (wr != 0 || v !== 2'b01 || d !== DW'(32'hAA) || e !== 1'b0) begin
      bad++; $display("FAIL rd_back got wr_cycles=%0d rsp=%b rdata=%h err=%b want 0/01/aa/0", wr, v, d, e);
    end
  endtask

  task automatic test_out_of_range();
    int w, wr, diffs; logic [1:0] v; logic [DW-1:0] d; logic e;
    logic [DW-1:0] snap [MS];
    for (int i = 0; i < MS; i++) snap[i] = mem[i];
    issue(0, 1'b1, AW'(MS), DW'(32'h55), w, wr, v, d, e);
    diffs = 0;
    for (int i = 0; i < MS; i++) if (mem[i] !== snap[i]) diffs++;
    total++;
    if (wr != 0 || e !== 1'b1 || v !== 2'b01 || d !== '0 || diffs != 0) begin
      bad++; $display("FAIL oor_write got wr_cycles=%0d err=%b rsp=%b rdata=%h diffs=%0d want 0/1/01/0/0", wr, e, v, d, diffs);
    end
    issue(1, 1'b0, AW'(200), '0, w, wr, v, d, e);
    total++;
    if (e !== 1'b1 || v !== 2'b10 || d !== '0) begin
      bad++; $display("FAIL oor_read got err=%b rsp=%b rdata=%h want 1/10/0", e, v, d);
    end
  endtask

  task automatic test_withdraw();
    int rdy_cnt, wr_cnt;
    rdy_cnt = 0; wr_cnt = 0;
    @(posedge clk_i); #1;
    req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = AW'(3);
    @(negedge clk_i);
    total++;
    if (req_ready !== 2'b01) begin
      bad++; $display("FAIL withdraw_grant got=%b want=01", req_ready);
    end
    @(posedge clk_i); #1;
    req_valid[0] = 1'b0;
    req_valid[1] = 1'b1; req_we[1] = 1'b1; req_addr[1] = AW'(2); req_wdata[1] = DW'(32'h77);
    @(negedge clk_i);
    if (req_ready != 2'b00) rdy_cnt++;
    @(posedge clk_i); #1;
    req_valid[1] = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk_i);
      if (req_ready != 2'b00) rdy_cnt++;
      if (mem_wr_en) wr_cnt++;
    end
    total++;
    if (rdy_cnt != 0 || wr_cnt != 0 || mem[2] !== DW'(2)) begin
      bad++; $display("FAIL withdraw got ready_cycles=%0d wr_cycles=%0d mem2=%h want 0/0/2", rdy_cnt, wr_cnt, mem[2]);
    end
  endtask

  task automatic test_req1_only();
    int w, wr; logic [1:0] v; logic [DW-1:0] d; logic e;
    @(negedge clk_i); #1;
    rst_i = 1'b0;
    #2;
    rst_i = 1'b1;
    issue(1, 1'b0, AW'(7), '0, w, wr, v, d, e);
    total++;
    if (w != 0 || v !== 2'b10 || d !== DW'(7)) begin
      bad++; $display("FAIL req1_only got wait=%0d rsp=%b rdata=%h want 0/10/7", w, v, d);
    end
  endtask

  // Pointer should now be 0 (last grant went to requester 1).
  task automatic test_fairness();
    logic [1:0] gseq [4];
    logic [1:0] rseq [4];
    int gcyc [4];
    int ng, nr, cyc, gap_bad;
    ng = 0; nr = 0; cyc = 0; gap_bad = 0;
    @(posedge clk_i); #1;
    req_valid = 2'b11; req_we = 2'b00; req_addr[0] = AW'(1); req_addr[1] = AW'(2);
    while ((ng < 4 || nr < 4) && cyc < 60) begin
      @(negedge clk_i);
      cyc++;
      if (rsp_valid != 2'b00 && nr < 4) begin rseq[nr] = rsp_valid; nr++; end
      if (req_ready != 2'b00 && ng < 4) begin
        gseq[ng] = req_ready; gcyc[ng] = cyc; ng++;
        if (ng == 4) begin @(posedge clk_i); #1; req_valid = 2'b00; end
      end
    end
    req_valid = 2'b00;
    total++;
    if (ng != 4 || nr != 4) begin
      bad++; $display("FAIL fair_timeout got grants=%0d rsps=%0d want 4/4", ng, nr);
    end else begin
      for (int k = 0; k < 4; k++) begin
        total++;
        if (gseq[k] !== ((k % 2 == 0) ? 2'b01 : 2'b10) || rseq[k] !== gseq[k]) begin
          bad++; $display("FAIL fair_order k=%0d got grant=%b rsp=%b want %b", k, gseq[k], rseq[k], (k % 2 == 0) ? 2'b01 : 2'b10);
        end
        if (k > 0 && gcyc[k] - gcyc[k-1] != 3) gap_bad++;
      end
      total++;
      if (gap_bad != 0) begin
        bad++; $display("FAIL fair_spacing got bad_gaps=%0d want 0", gap_bad);
      end
    end
    repeat (3) @(negedge clk_i);
  endtask

  task automatic test_back_to_back();
    int k, cyc, last, gap_bad, w, wr; logic [1:0] v; logic [DW-1:0] d; logic e;
    k = 0; cyc = 0; last = -1; gap_bad = 0;
    @(posedge clk_i); #1;
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = AW'(10); req_wdata[0] = DW'(32'hC0DE0000);
    while (k < 4 && cyc < 40) begin
      @(negedge clk_i);
      cyc++;
      if (req_ready[0]) begin
        if (last >= 0 && cyc - last != 3) gap_bad++;
        last = cyc; k++;
        @(posedge clk_i); #1;
        if (k < 4) begin
          req_addr[0] = AW'(10 + k); req_wdata[0] = DW'(32'hC0DE0000 + k);
        end else req_valid[0] = 1'b0;
      end
    end
    req_valid[0] = 1'b0;
    total++;
    if (k != 4 || gap_bad != 0) begin
      bad++; $display("FAIL b2b_writes got accepts=%0d bad_gaps=%0d want 4/0", k, gap_bad);
    end
    repeat (3) @(negedge clk_i);
    for (int j = 0; j < 4; j++) begin
      issue(j % 2, 1'b0, AW'(10 + j), '0, w, wr, v, d, e);
      total++;
      if (d !== DW'(32'hC0DE0000 + j) || v !== ((j % 2 == 1) ? 2'b10 : 2'b01) || e !== 1'b0) begin
        bad++; $display("FAIL b2b_read j=%0d got rdata=%h rsp=%b err=%b want %h", j, d, v, e, DW'(32'hC0DE0000 + j));
      end
    end
  endtask

  task automatic test_reset_abort();
    int rsp_cnt, busy_cnt;
    rsp_cnt = 0; busy_cnt = 0;
    @(posedge clk_i); #1;
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = AW'(9); req_wdata[0] = DW'(32'h3C);
    @(negedge clk_i);
    total++;
    if (req_ready !== 2'b01) begin
      bad++; $display("FAIL abort_grant got=%b want=01", req_ready);
    end
    @(posedge clk_i); #2;
    total++;
    if (mem_wr_en !== 1'b1) begin
      bad++; $display("FAIL abort_access got wr_en=%b want=1", mem_wr_en);
    end
    rst_i = 1'b0;
    #1;
    total++;
    if (mem_wr_en !== 1'b0 || busy !== 1'b0 || mem_addr !== '0) begin
      bad++; $display("FAIL abort_drop got wr_en=%b busy=%b addr=%h want 0", mem_wr_en, busy, mem_addr);
    end
    req_valid = 2'b00;
    @(negedge clk_i);
    @(negedge clk_i); #1;
    rst_i = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_i);
      if (rsp_valid != 2'b00) rsp_cnt++;
      if (busy) busy_cnt++;
    end
    total++;
    if (rsp_cnt != 0 || busy_cnt != 0 || mem[9] !== DW'(9)) begin
      bad++; $display("FAIL abort_after got rsp_cycles=%0d busy_cycles=%0d mem9=%h want 0/0/9", rsp_cnt, busy_cnt, mem[9]);
    end
  endtask

  initial begin
    total = 0; bad = 0;
    rst_i = 1'b0;
    req_valid = 2'b00; req_we = 2'b00; req_addr = '0; req_wdata = '0;
    fork
      env_mem();
      scoreboard();
    join_none
    test_reset();
    test_fresh_read();
    test_write_read();
    test_out_of_range();
    test_withdraw();
    test_req1_only();
    test_fairness();
    test_back_to_back();
    test_reset_abort();
    repeat (4) @(negedge clk_i);
    total++;
    if (sb_q.size() != 0) begin
      bad++; $display("FAIL sb_drain got pending=%0d want 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
